// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: function codes, FSM states, cond layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int COND_W  = 3;
  localparam int TIMER_W = 4;

  // Bit positions inside the {sign, carry, zero} condition register
  localparam int COND_ZERO  = 0;
  localparam int COND_CARRY = 1;
  localparam int COND_SIGN  = 2;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_D = 1'b1;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_INC = 3'd1,
    FN_AND = 3'd2,
    FN_OR  = 3'd3,
    FN_XOR = 3'd4,
    FN_NOT = 3'd5,
    FN_SHL = 3'd6,
    FN_CLR = 3'd7
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } alu_state_e;

  // Only the adder path produces a meaningful carry-out
  function automatic logic func_writes_carry(alu_func_e f);
    return (f == FN_ADD) || (f == FN_INC);
  endfunction

endpackage

// File: rtl/relay_settle_timer.sv
// Down-counter that times relay settling; expire marks the final tick before zero.
// Latency: load takes effect next edge; expire is combinational on the current count.
// Backpressure: none; load wins over tick, counting stops at zero.
module relay_settle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Load, then decrement once per tick until the counter reaches zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // The tick that takes the count from one to zero is the expiring one
  assign expire = tick && (count == WIDTH'(1));

endmodule

// File: rtl/alu_result_stage.sv
// Latches an ALU result into A or D plus {sign,carry,zero} after a relay settle delay.
// Latency: start at edge k -> registers written and done raised at edge k+SETTLE_CYCLES.
// Backpressure: start is ignored (not queued) while busy; next accepted in IDLE after DONE.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4  // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        func,
  input  logic              dest,
  input  logic [DATA_W-1:0] alu_val,
  input  logic              alu_carry,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_d,
  output logic [COND_W-1:0] cond
);

  alu_state_e        state;
  alu_func_e         op_func;
  logic              op_dest;
  logic              accept;
  logic              settle_tick;
  logic              settle_expire;
  logic [DATA_W-1:0] result;
  logic [COND_W-1:0] cond_next;

  assign accept      = (state == ST_IDLE) && start;
  assign settle_tick = (state == ST_SETTLE);

  relay_settle_timer #(
    .WIDTH (TIMER_W)
  ) u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (TIMER_W'(SETTLE_CYCLES)),
    .tick     (settle_tick),
    .expire   (settle_expire)
  );

  // Value to latch and the condition flags it produces; carry only moves on adder ops
  always_comb begin
    result    = (op_func == FN_CLR) ? '0 : alu_val;
    cond_next = cond;
    cond_next[COND_SIGN] = result[DATA_W-1];
    cond_next[COND_ZERO] = (result == '0);
    if (func_writes_carry(op_func)) begin
      cond_next[COND_CARRY] = alu_carry;
    end
  end

  // Sequencer FSM: capture the request, wait for the relays, write back, pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_func <= FN_ADD;
      op_dest <= DEST_A;
      busy    <= 1'b0;
      done    <= 1'b0;
      reg_a   <= '0;
      reg_d   <= '0;
      cond    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // func/dest are frozen here so later input changes cannot disturb the op
            op_func <= alu_func_e'(func);
            op_dest <= dest;
            busy    <= 1'b1;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_expire) begin
            if (op_dest == DEST_D) begin
              reg_d <= result;
            end else begin
              reg_a <= result;
            end
            cond  <= cond_next;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed ops with hand-computed results.
// Latency: checks done timing cycle by cycle against SETTLE_CYCLES.
// Backpressure: drives start during busy and expects it to be ignored.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int SC = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] func;
  logic       dest;
  logic [7:0] alu_val;
  logic       alu_carry;
  logic       busy;
  logic       done;
  logic [7:0] reg_a;
  logic [7:0] reg_d;
  logic [2:0] cond;

  alu_result_stage #(.SETTLE_CYCLES(SC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .func      (func),
    .dest      (dest),
    .alu_val   (alu_val),
    .alu_carry (alu_carry),
    .busy      (busy),
    .done      (done),
    .reg_a     (reg_a),
    .reg_d     (reg_d),
    .cond      (cond)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [2:0] cond;
  } wb_t;

  typedef struct {
    bit         drain;
    logic       busy;
    logic       done;
    logic [7:0] a;
    logic [7:0] d;
    logic [2:0] cond;
    string      name;
  } probe_t;

  wb_t    exp_q[$];
  probe_t probe_q[$];
  wb_t    mon_e;
  probe_t mon_p;

  int checks = 0;
  int fails  = 0;

  // reference state kept by the stimulus side
  logic [7:0] m_a;
  logic [7:0] m_d;
  logic [2:0] m_cond;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: scoreboard pop on every done pulse, plus queued snapshot probes
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL done_pulse: got unexpected done with nothing pending (a=%h d=%h cond=%b)",
                 reg_a, reg_d, cond);
      end else begin
        mon_e = exp_q.pop_front();
        if ({reg_a, reg_d, cond} !== {mon_e.a, mon_e.d, mon_e.cond}) begin
          fails++;
          $display("FAIL writeback: got a=%h d=%h cond=%b, expected a=%h d=%h cond=%b",
                   reg_a, reg_d, cond, mon_e.a, mon_e.d, mon_e.cond);
        end
      end
    end
    if (probe_q.size() != 0) begin
      mon_p = probe_q.pop_front();
      checks++;
      if (mon_p.drain) begin
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL %s: %0d expected done pulses never arrived, expected 0", mon_p.name, exp_q.size());
        end
      end else if ({busy, done, reg_a, reg_d, cond} !==
                   {mon_p.busy, mon_p.done, mon_p.a, mon_p.d, mon_p.cond}) begin
        fails++;
        $display("FAIL %s: got busy=%b done=%b a=%h d=%h cond=%b, expected busy=%b done=%b a=%h d=%h cond=%b",
                 mon_p.name, busy, done, reg_a, reg_d, cond,
                 mon_p.busy, mon_p.done, mon_p.a, mon_p.d, mon_p.cond);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string name, input logic b, input logic dn,
                      input logic [7:0] a, input logic [7:0] d, input logic [2:0] c);
    probe_t p;
    p.drain = 1'b0;
    p.busy  = b;
    p.done  = dn;
    p.a     = a;
    p.d     = d;
    p.cond  = c;
    p.name  = name;
    probe_q.push_back(p);
  endtask

  // One operation; restart pulses start during SETTLE, scramble alters func/dest/carry after capture
  task automatic run_op(input string name, input logic [2:0] f, input logic dst,
                        input logic [7:0] v, input logic c,
                        input bit restart, input bit scramble);
    logic [7:0] res;
    logic [7:0] na;
    logic [7:0] nd;
    logic [2:0] nc;
    wb_t        w;
    res = (f == 3'd7) ? 8'h00 : v;
    na  = (dst == 1'b0) ? res : m_a;
    nd  = (dst == 1'b1) ? res : m_d;
    nc[2] = res[7];
    nc[1] = (f == 3'd0 || f == 3'd1) ? c : m_cond[1];
    nc[0] = (res == 8'h00);
    w.a = na;
    w.d = nd;
    w.cond = nc;
    exp_q.push_back(w);
    func      = f;
    dest      = dst;
    alu_val   = v;
    alu_carry = c;
    start     = 1'b1;
    for (int i = 1; i <= SC + 2; i++) begin
      step();
      start = restart ? (i <= 3) : 1'b0;
      if (scramble && i == 1) begin
        func      = FN_ADD;
        dest      = ~dst;
        alu_carry = ~c;
      end
      if (i >= SC + 1)
        snap($sformatf("%s_c%0d", name, i), (i <= SC + 1), (i == SC + 1), na, nd, nc);
      else
        snap($sformatf("%s_c%0d", name, i), 1'b1, 1'b0, m_a, m_d, m_cond);
    end
    m_a    = na;
    m_d    = nd;
    m_cond = nc;
  endtask

  initial begin
    probe_t dp;
    reset     = 1'b1;
    start     = 1'b0;
    func      = 3'd0;
    dest      = 1'b0;
    alu_val   = 8'h00;
    alu_carry = 1'b0;
    m_a       = 8'h00;
    m_d       = 8'h00;
    m_cond    = 3'b000;
    step();
    step();
    step();
    reset = 1'b0;
    snap("reset_state", 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    step();

    // SHL into A: carry input ignored, cond = {0,held 0,0}
    run_op("shl_a",     FN_SHL, DEST_A, 8'h03, 1'b1, 1'b0, 1'b0);
    // ADD into D with carry-out and zero result
    run_op("add_d",     FN_ADD, DEST_D, 8'h00, 1'b1, 1'b0, 1'b0);
    // CLR ignores alu_val, keeps carry from the ADD
    run_op("clr_a",     FN_CLR, DEST_A, 8'hA5, 1'b0, 1'b0, 1'b0);
    // INC loads carry=0, negative result
    run_op("inc_d",     FN_INC, DEST_D, 8'h80, 1'b0, 1'b0, 1'b0);
    // start pulsed during SETTLE must be ignored
    run_op("or_restart", FN_OR, DEST_A, 8'h5A, 1'b1, 1'b1, 1'b0);
    run_op("add_a",     FN_ADD, DEST_A, 8'h7F, 1'b1, 1'b0, 1'b0);
    // XOR with func/dest/carry changed after capture: carry must hold at 1
    run_op("xor_scramble", FN_XOR, DEST_D, 8'h80, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of SETTLE aborts the op
    func      = FN_AND;
    dest      = DEST_D;
    alu_val   = 8'hFF;
    alu_carry = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset  = 1'b1;
    m_a    = 8'h00;
    m_d    = 8'h00;
    m_cond = 3'b000;
    snap("reset_mid_settle", 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < SC + 3; i++) step();
    snap("after_abort_idle", 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    step();
    run_op("not_after_reset", FN_NOT, DEST_A, 8'hF0, 1'b1, 1'b0, 1'b0);

    dp.drain = 1'b1;
    dp.busy  = 1'b0;
    dp.done  = 1'b0;
    dp.a     = 8'h00;
    dp.d     = 8'h00;
    dp.cond  = 3'b000;
    dp.name  = "drain";
    probe_q.push_back(dp);
    step();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
